// File: rtl/keypad_scanner_pkg.sv
// Shared types, constants and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAND    = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REL     = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } scan_res_e;

    // Hex code of the key at {row, col}; index = row*4 + col.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Number of active rows in one column sample, saturated at 2 ("many").
    function automatic logic [1:0] row_hits(input logic [3:0] lows);
        logic [1:0] n;
        case (lows)
            4'b0000:                            n = 2'd0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: n = 2'd1;
            default:                            n = 2'd2;
        endcase
        return n;
    endfunction

    // Row index of a single active row; only meaningful when row_hits()==1.
    function automatic logic [1:0] low_row(input logic [3:0] lows);
        logic [1:0] r;
        case (lows)
            4'b0001: r = 2'd0;
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // One-cold column strobe pattern for a column index.
    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] s;
        case (idx)
            2'd0:    s = 4'b1110;
            2'd1:    s = 4'b1101;
            2'd2:    s = 4'b1011;
            2'd3:    s = 4'b0111;
            default: s = 4'b1110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, grouped for port passing.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col, key_code, key_valid, key_held
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, key_held
    );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous keypad rows; idles at "no row active".
module sync_2ff #(
    parameter int          W       = 4,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage resynchronization into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, full-scan classification, debounce FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);

    localparam int CW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_TGT   = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DEB_MAX   = '1;
    // With a single-scan debounce the first matching scan already qualifies.
    localparam bit ONE_SCAN = (DEBOUNCE_SCANS <= 1);

    logic [3:0]    row_sync_s;
    logic [CW-1:0] slot_r;
    logic [1:0]    col_idx_r;
    logic [3:0]    col_r;
    logic [1:0]    hits_r;
    logic [3:0]    hit_idx_r;

    kp_state_e     state_r, state_n;
    logic [3:0]    cand_r, cand_n;
    logic [DW-1:0] deb_r, deb_n;
    logic [3:0]    key_code_r, key_code_n;
    logic          key_valid_r, key_valid_n;
    logic          key_held_r, key_held_n;

    logic          slot_end_s;
    logic          scan_done_s;
    logic [3:0]    lows_s;
    logic [1:0]    col_hits_s;
    logic [2:0]    sum_s;
    logic [1:0]    total_s;
    logic [3:0]    idx_s;
    scan_res_e     res_s;
    logic          is_key_s;
    logic [3:0]    key_s;
    logic [DW-1:0] deb_inc_s;

    sync_2ff #(.W(4), .RST_VAL(4'hF)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row),
        .q     (row_sync_s)
    );

    // Classify the current column sample and fold it into the running scan result.
    always_comb begin
        slot_end_s  = (slot_r == SLOT_LAST);
        scan_done_s = slot_end_s && (col_idx_r == 2'd3);
        lows_s      = ~row_sync_s;
        col_hits_s  = row_hits(lows_s);
        sum_s       = {1'b0, hits_r} + {1'b0, col_hits_s};
        if (sum_s >= 3'd2) begin
            total_s = 2'd2;
        end else begin
            total_s = sum_s[1:0];
        end
        if (hits_r == 2'd0) begin
            idx_s = {low_row(lows_s), col_idx_r};
        end else begin
            idx_s = hit_idx_r;
        end
        case (total_s)
            2'd0:    res_s = RES_NONE;
            2'd1:    res_s = RES_KEY;
            default: res_s = RES_MULTI;
        endcase
        is_key_s = (res_s == RES_KEY);
        key_s    = KEYMAP[idx_s];
        if (deb_r == DEB_MAX) begin
            deb_inc_s = deb_r;
        end else begin
            deb_inc_s = deb_r + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    // Slot timer and column strobe; the strobe moves on the same edge as the index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_r    <= '0;
            col_idx_r <= 2'd0;
            col_r     <= 4'b1110;
        end else if (slot_end_s) begin
            slot_r    <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= col_strobe(col_idx_r + 2'd1);
        end else begin
            slot_r    <= slot_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Per-scan hit accumulator, cleared once column 3 has been sampled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hits_r    <= 2'd0;
            hit_idx_r <= 4'd0;
        end else if (scan_done_s) begin
            hits_r    <= 2'd0;
            hit_idx_r <= 4'd0;
        end else if (slot_end_s) begin
            hits_r    <= total_s;
            hit_idx_r <= idx_s;
        end else begin
            hits_r    <= hits_r;
            hit_idx_r <= hit_idx_r;
        end
    end

    // Debounce FSM state and registered key outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cand_r      <= 4'd0;
            deb_r       <= '0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            cand_r      <= cand_n;
            deb_r       <= deb_n;
            key_code_r  <= key_code_n;
            key_valid_r <= key_valid_n;
            key_held_r  <= key_held_n;
        end
    end

    // Next-state logic: one decision per completed full scan.
    always_comb begin
        state_n     = state_r;
        cand_n      = cand_r;
        deb_n       = deb_r;
        key_code_n  = key_code_r;
        key_valid_n = 1'b0;
        key_held_n  = key_held_r;
        if (scan_done_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (is_key_s) begin
                        cand_n = key_s;
                        if (ONE_SCAN) begin
                            state_n = ST_PRESSED; key_code_n = key_s;
                            key_valid_n = 1'b1; key_held_n = 1'b1; deb_n = '0;
                        end else begin
                            state_n = ST_CAND; deb_n = DW'(1);
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_CAND: begin
                    if (is_key_s && (key_s == cand_r)) begin
                        if (deb_inc_s >= DEB_TGT) begin
                            state_n = ST_PRESSED; key_code_n = cand_r;
                            key_valid_n = 1'b1; key_held_n = 1'b1; deb_n = '0;
                        end else begin
                            deb_n = deb_inc_s;
                        end
                    end else if (is_key_s) begin
                        cand_n = key_s;
                        if (ONE_SCAN) begin
                            state_n = ST_PRESSED; key_code_n = key_s;
                            key_valid_n = 1'b1; key_held_n = 1'b1; deb_n = '0;
                        end else begin
                            deb_n = DW'(1);
                        end
                    end else begin
                        state_n = ST_IDLE; deb_n = '0;
                    end
                end
                ST_PRESSED: begin
                    // A different key without an intervening release stays here silently.
                    if (is_key_s) begin
                        state_n = ST_PRESSED;
                    end else if (ONE_SCAN) begin
                        state_n = ST_IDLE; key_held_n = 1'b0; deb_n = '0;
                    end else begin
                        state_n = ST_REL; deb_n = DW'(1);
                    end
                end
                ST_REL: begin
                    if (is_key_s) begin
                        state_n = ST_PRESSED; deb_n = '0;
                    end else if (deb_inc_s >= DEB_TGT) begin
                        state_n = ST_IDLE; key_held_n = 1'b0; deb_n = '0;
                    end else begin
                        deb_n = deb_inc_s;
                    end
                end
                default: begin
                    state_n = ST_IDLE; deb_n = '0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    assign kp.col       = col_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] keys;     // keys[r*4+c] = key at row r, column c is pressed
    logic [3:0]  row_m;
    int          total;
    int          bad;
    logic [3:0]  exp_q [$];

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_TICKS(8), .DEBOUNCE_SCANS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row_m = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (kif.col[c] == 1'b0)) row_m[r] = 1'b0;
            end
        end
    end
    assign kif.row = row_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every key_valid pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            if (exp_q.size() > 0) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                chk("key_code", {28'd0, kif.key_code}, {28'd0, e});
                chk("held_at_valid", {31'd0, kif.key_held}, 32'd1);
            end else begin
                chk("spurious_valid", {31'd0, kif.key_valid}, 32'd0);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        keys[r*4+c] = 1'b1;
    endtask

    task automatic release_all();
        keys = 16'd0;
    endtask

    // Accept window: press to pulse must fit within about three scans.
    task automatic expect_accept(input string tag);
        wait_cyc(120);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
        chk({tag, "_held"}, {31'd0, kif.key_held}, 32'd1);
    endtask

    task automatic expect_release(input string tag);
        wait_cyc(10);
        chk({tag, "_held_early"}, {31'd0, kif.key_held}, 32'd1);
        wait_cyc(120);
        chk({tag, "_held_off"}, {31'd0, kif.key_held}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        keys  = 16'd0;
        reset = 1'b0;

        // 1. reset values and first column step
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_col", {28'd0, kif.col}, 32'hE);
        chk("rst_code", {28'd0, kif.key_code}, 32'd0);
        chk("rst_valid", {31'd0, kif.key_valid}, 32'd0);
        chk("rst_held", {31'd0, kif.key_held}, 32'd0);
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("col_before_step", {28'd0, kif.col}, 32'hE);
        @(posedge clk);
        #1 chk("col_step", {28'd0, kif.col}, 32'hD);
        @(negedge clk);

        // 2. hold '5'
        exp_q.push_back(4'h5);
        press(1, 1);
        expect_accept("k5");
        release_all();
        expect_release("k5");

        // 3. short '9' press
        press(2, 2);
        wait_cyc(20);
        release_all();
        wait_cyc(150);
        chk("short_held", {31'd0, kif.key_held}, 32'd0);
        chk("short_code", {28'd0, kif.key_code}, 32'h5);

        // 4. '1'+'2' together, then release '2'
        press(0, 0);
        press(0, 1);
        wait_cyc(150);
        chk("multi_held", {31'd0, kif.key_held}, 32'd0);
        exp_q.push_back(4'h1);
        keys[0*4+1] = 1'b0;
        expect_accept("k1");
        release_all();
        expect_release("k1");

        // 5a. 'D' twice
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(4'hD);
            press(3, 3);
            expect_accept("kD");
            release_all();
            expect_release("kD");
        end

        // 5b. slide '5' -> '6' without a gap, then re-press '6'
        exp_q.push_back(4'h5);
        press(1, 1);
        expect_accept("slide5");
        keys = 16'd0;
        keys[1*4+2] = 1'b1;
        wait_cyc(150);
        chk("slide_held", {31'd0, kif.key_held}, 32'd1);
        chk("slide_code", {28'd0, kif.key_code}, 32'h5);
        release_all();
        expect_release("slide6");
        exp_q.push_back(4'h6);
        press(1, 2);
        expect_accept("k6");
        release_all();
        expect_release("k6");

        // 6. reset while 'A' held
        exp_q.push_back(4'hA);
        press(0, 3);
        expect_accept("kA");
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_col", {28'd0, kif.col}, 32'hE);
        chk("mid_rst_code", {28'd0, kif.key_code}, 32'd0);
        chk("mid_rst_valid", {31'd0, kif.key_valid}, 32'd0);
        chk("mid_rst_held", {31'd0, kif.key_held}, 32'd0);
        reset = 1'b1;
        exp_q.push_back(4'hA);
        expect_accept("kA_again");
        release_all();
        expect_release("kA_again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
